// File: rtl/fpu_to_int.sv
// Iterative custom-float (s/6-bit exp/25-bit mant, hidden 1) to signed 32-bit integer.
// Shifts one bit per cycle, rounds to nearest with ties away from zero.
module fpu_to_int #(
  parameter int BIAS     = 31,
  parameter bit SATURATE = 1'b1
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  localparam logic [3:0] ST_EXACT   = 4'b0001;
  localparam logic [3:0] ST_INEXACT = 4'b0010;
  localparam logic [3:0] ST_OVF     = 4'b0100;
  localparam logic [3:0] ST_UNF     = 4'b1000;

  typedef enum logic [1:0] {IDLE, CLASSIFY, SHIFT, ROUND} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [5:0]  exp_q, exp_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  status_q, status_d;

  logic signed [7:0] e_s, diff_s;
  logic [4:0]  k;
  logic [31:0] ovf_val, rnd;
  logic        fin;
  logic [31:0] fin_data;
  logic [3:0]  fin_stat;

  always_comb begin
    e_s     = 8'({2'b00, exp_q}) - 8'(BIAS);
    diff_s  = e_s - 8'sd25;
    k       = diff_s[7] ? 5'(-diff_s) : 5'(diff_s);
    ovf_val = SATURATE ? (sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h0;
    rnd     = mag_q + {31'b0, guard_q};
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mag_d    = mag_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    status_d = status_q;
    fin      = 1'b0;
    fin_data = 32'h0;
    fin_stat = ST_EXACT;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d   = op_in[31];
          exp_d    = op_in[30:25];
          mag_d    = {6'b0, 1'b1, op_in[24:0]};
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = CLASSIFY;
        end
      end
      CLASSIFY: begin
        if (exp_q == 6'd0) begin
          fin = 1'b1; fin_data = 32'h0; fin_stat = ST_EXACT;
        end else if (exp_q == 6'd63) begin
          fin = 1'b1; fin_data = ovf_val; fin_stat = ST_OVF;
        end else if (e_s == 8'sd31) begin
          // -2^31 is the one E=31 value that still fits.
          fin = 1'b1;
          if (sign_q && mag_q[24:0] == 25'd0) begin
            fin_data = 32'h8000_0000; fin_stat = ST_EXACT;
          end else begin
            fin_data = ovf_val; fin_stat = ST_OVF;
          end
        end else if (e_s <= -8'sd2) begin
          fin = 1'b1; fin_data = 32'h0; fin_stat = ST_UNF;
        end else begin
          cnt_d   = k;
          left_d  = (diff_s > 0);
          state_d = (k != 5'd0) ? SHIFT : ROUND;
        end
        if (fin) begin
          data_d   = fin_data;
          status_d = fin_stat;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = ROUND;
      end
      ROUND: begin
        data_d   = sign_q ? -rnd : rnd;
        status_d = (guard_q | sticky_q) ? ST_INEXACT : ST_EXACT;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock100KHz) begin
    if (!reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= 6'd0;
      mag_q    <= 32'h0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= 5'd0;
      left_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 32'h0;
      status_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mag_q    <= mag_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fpu_to_int.sv
// Directed bench for fpu_to_int: saturating and non-saturating instances share stimulus.
module tb_fpu_to_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_in;
  logic        busy, done, busy_n, done_n;
  logic [31:0] data_out, data_n;
  logic [3:0]  status_out, status_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_to_int #(.BIAS(31), .SATURATE(1'b1)) u_dut (
    .clock100KHz(clk), .reset(reset), .start(start), .op_in(op_in),
    .busy(busy), .done(done), .data_out(data_out), .status_out(status_out));

  fpu_to_int #(.BIAS(31), .SATURATE(1'b0)) u_ns (
    .clock100KHz(clk), .reset(reset), .start(start), .op_in(op_in),
    .busy(busy_n), .done(done_n), .data_out(data_n), .status_out(status_n));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is 1 time unit past a rising edge; start is taken on the next edge.
  task automatic conv(input string tag, input logic [31:0] op, input logic [31:0] exp_d,
                      input logic [3:0] exp_s, input int exp_lat,
                      input int glitch_at, input logic [31:0] glitch_op);
    int n;
    start = 1'b1;
    op_in = op;
    @(posedge clk); #1;
    start = 1'b0;
    op_in = 32'h0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (n == glitch_at) begin
        start = 1'b1;
        op_in = glitch_op;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_data"}, data_out, exp_d);
    chk({tag, "_stat"}, {28'h0, status_out}, {28'h0, exp_s});
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    start = 1'b0;
    op_in = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_stat", {28'h0, status_out}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    conv("one",     32'h3E00_0000, 32'h0000_0001, 4'b0001, 27, 0, 32'h0);
    conv("p2_5",    32'h4080_0000, 32'h0000_0003, 4'b0010, 26, 0, 32'h0);
    conv("m2_5",    32'hC080_0000, 32'hFFFF_FFFD, 4'b0010, 26, 0, 32'h0);
    conv("p1_5",    32'h3F00_0000, 32'h0000_0002, 4'b0010, 27, 0, 32'h0);
    conv("m1_5",    32'hBF00_0000, 32'hFFFF_FFFE, 4'b0010, 27, 0, 32'h0);
    conv("e25",     32'h7000_0000, 32'h0200_0000, 4'b0001, 2, 0, 32'h0);
    conv("e30",     32'h7BFF_FFFF, 32'h7FFF_FFE0, 4'b0001, 7, 0, 32'h0);
    conv("zero",    32'h0000_0000, 32'h0000_0000, 4'b0001, 1, 0, 32'h0);
    conv("ovf_p",   32'h7E00_0000, 32'h7FFF_FFFF, 4'b0100, 1, 0, 32'h0);
    chk("ovf_p_ns_data", data_n, 32'h0);
    chk("ovf_p_ns_stat", {28'h0, status_n}, 32'h4);
    conv("ovf_m",   32'hFE00_0000, 32'h8000_0000, 4'b0100, 1, 0, 32'h0);
    chk("ovf_m_ns_data", data_n, 32'h0);
    chk("ovf_m_ns_stat", {28'h0, status_n}, 32'h4);
    conv("min_int", 32'hFC00_0000, 32'h8000_0000, 4'b0001, 1, 0, 32'h0);
    chk("min_int_ns_data", data_n, 32'h8000_0000);
    conv("p2_31",   32'h7C00_0000, 32'h7FFF_FFFF, 4'b0100, 1, 0, 32'h0);
    chk("p2_31_ns_data", data_n, 32'h0);
    conv("unf",     32'h3A00_0000, 32'h0000_0000, 4'b1000, 1, 0, 32'h0);
    conv("half",    32'h3C00_0000, 32'h0000_0001, 4'b0010, 28, 0, 32'h0);
    conv("ignore",  32'h3E00_0000, 32'h0000_0001, 4'b0001, 27, 3, 32'h7E00_0000);

    // Reset pulse while the shifter is mid-way through a conversion.
    start = 1'b1;
    op_in = 32'h3E00_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_done", {31'h0, done}, 32'h0);
    chk("mrst_data", data_out, 32'h0);
    chk("mrst_stat", {28'h0, status_out}, 32'h0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("mrst_nodone", {31'h0, seen}, 32'h0);
    conv("after_rst", 32'h4080_0000, 32'h0000_0003, 4'b0010, 26, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
